// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with combinational fetch lookup and a two-stage resolve/update pipe.
// Latency: lookup 0 cycles; update reads at stage 1, writes the array one edge later.
// Backpressure: none; a resolved branch is accepted every cycle, stage 2 forwards to stage 1.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              btb_clk,
  input  logic              btb_rst,
  input  logic [ADDR_W-1:0] btb_fetch_pc,
  output logic              btb_pred_hit,
  output logic              btb_pred_taken,
  output logic [ADDR_W-1:0] btb_pred_target,
  input  logic              btb_upd_valid,
  input  logic [ADDR_W-1:0] btb_upd_pc,
  input  logic              btb_upd_taken,
  input  logic [ADDR_W-1:0] btb_upd_target,
  output logic              btb_fsm_branch_taken,
  output logic [1:0]        btb_fsm_current_prediction,
  input  logic [1:0]        btb_fsm_new_prediction
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Entry storage
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  // Stage-1 pipeline registers (pending stage-2 write)
  logic              s1_valid_q, s1_valid_d;
  logic              s1_taken_q, s1_taken_d;
  logic              s1_hit_q, s1_hit_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [ADDR_W-1:0] s1_target_q, s1_target_d;
  logic              fsm_taken_q, fsm_taken_d;
  logic [1:0]        fsm_cur_q, fsm_cur_d;

  // PC bit fields
  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             unused_pc_low;

  assign fetch_idx     = btb_fetch_pc[IDX_W+1:2];
  assign fetch_tag     = btb_fetch_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx       = btb_upd_pc[IDX_W+1:2];
  assign upd_tag       = btb_upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_low = ^{btb_fetch_pc[1:0], btb_upd_pc[1:0]};

  // Fetch lookup: reads committed array state only, no bypass of a same-cycle write
  always_comb begin
    btb_pred_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    btb_pred_taken  = btb_pred_hit && ctr_q[fetch_idx][1];
    btb_pred_target = btb_pred_hit ? target_q[fetch_idx] : '0;
  end

  assign btb_fsm_branch_taken       = fsm_taken_q;
  assign btb_fsm_current_prediction = fsm_cur_q;

  // Stage-2 write intent, shared by the array update and the stage-1 forward path
  logic       s2_wr;
  logic [1:0] s2_ctr;
  logic       s2_fwd;
  logic       upd_hit;
  logic [1:0] upd_ctr;

  // Stage 1: capture the resolved branch, forwarding a pending same-index write
  always_comb begin
    s2_wr  = s1_valid_q && (s1_hit_q || s1_taken_q);
    s2_ctr = s1_hit_q ? btb_fsm_new_prediction : 2'b10;
    s2_fwd = s2_wr && (s1_idx_q == upd_idx);
    if (s2_fwd) begin
      // The pending write defines the entry's tag; a different tag is a miss
      upd_hit = (s1_tag_q == upd_tag);
      upd_ctr = s2_ctr;
    end else begin
      upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_ctr = ctr_q[upd_idx];
    end

    s1_valid_d  = btb_upd_valid;
    s1_taken_d  = s1_taken_q;
    s1_hit_d    = s1_hit_q;
    s1_idx_d    = s1_idx_q;
    s1_tag_d    = s1_tag_q;
    s1_target_d = s1_target_q;
    fsm_taken_d = fsm_taken_q;
    fsm_cur_d   = fsm_cur_q;
    if (btb_upd_valid) begin
      s1_taken_d  = btb_upd_taken;
      s1_hit_d    = upd_hit;
      s1_idx_d    = upd_idx;
      s1_tag_d    = upd_tag;
      s1_target_d = btb_upd_target;
      fsm_taken_d = btb_upd_taken;
      fsm_cur_d   = upd_hit ? upd_ctr : 2'b00;
    end
  end

  // Stage 2: write back the FSM's counter on a hit, or allocate on a taken miss
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (s2_wr) begin
      ctr_d[s1_idx_q] = s2_ctr;
      if (s1_taken_q) begin
        target_d[s1_idx_q] = s1_target_q;
      end
      if (!s1_hit_q) begin
        valid_d[s1_idx_q] = 1'b1;
        tag_d[s1_idx_q]   = s1_tag_q;
      end
    end
  end

  // State registers; reset wins over any pending stage-2 write
  always_ff @(posedge btb_clk) begin
    if (btb_rst) begin
      valid_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      s1_valid_q  <= 1'b0;
      s1_taken_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_tag_q    <= '0;
      s1_target_q <= '0;
      fsm_taken_q <= 1'b0;
      fsm_cur_q   <= 2'b00;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      target_q    <= target_d;
      ctr_q       <= ctr_d;
      s1_valid_q  <= s1_valid_d;
      s1_taken_q  <= s1_taken_d;
      s1_hit_q    <= s1_hit_d;
      s1_idx_q    <= s1_idx_d;
      s1_tag_q    <= s1_tag_d;
      s1_target_q <= s1_target_d;
      fsm_taken_q <= fsm_taken_d;
      fsm_cur_q   <= fsm_cur_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus randomized update bursts.
// Latency: lookups checked after the pipe drains; stage-1 outputs checked 1 ns after each edge.
// Backpressure: none to model; updates are driven back to back or with random gaps.
module tb_branch_target_buffer;

  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        fsm_taken;
  logic [1:0]  fsm_cur;
  logic [1:0]  fsm_new;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(ENT), .ADDR_W(32)) dut (
    .btb_clk                    (clk),
    .btb_rst                    (rst),
    .btb_fetch_pc               (fetch_pc),
    .btb_pred_hit               (pred_hit),
    .btb_pred_taken             (pred_taken),
    .btb_pred_target            (pred_target),
    .btb_upd_valid              (upd_valid),
    .btb_upd_pc                 (upd_pc),
    .btb_upd_taken              (upd_taken),
    .btb_upd_target             (upd_target),
    .btb_fsm_branch_taken       (fsm_taken),
    .btb_fsm_current_prediction (fsm_cur),
    .btb_fsm_new_prediction     (fsm_new)
  );

  // 2-bit saturating counter step
  function automatic logic [1:0] sat(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // External prediction FSM attached to the BTB
  assign fsm_new = sat(fsm_cur, fsm_taken);

  // Reference model: one record per index, updates applied in program order
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  logic [1:0]  m_ctr   [ENT];
  logic [1:0]  last_cur;
  logic        last_tk;

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 2'b01;
    end
    last_cur = 2'b00;
    last_tk  = 1'b0;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int unsigned i = (pc / 4) % ENT;
    return m_valid[i] && (m_tag[i] == pc / (4 * ENT));
  endfunction

  task automatic check_lookup(input logic [31:0] pc);
    int unsigned i;
    bit          h;
    logic [31:0] et;
    fetch_pc = pc;
    #1;
    i  = (pc / 4) % ENT;
    h  = model_hit(pc);
    et = h ? m_tgt[i] : 32'd0;
    n_checks++;
    if (pred_hit !== h) begin
      n_fail++; $display("FAIL lookup_hit pc=%h got=%b want=%b", pc, pred_hit, h);
    end
    n_checks++;
    if (pred_taken !== (h && m_ctr[i][1])) begin
      n_fail++; $display("FAIL lookup_taken pc=%h got=%b want=%b", pc, pred_taken, h && m_ctr[i][1]);
    end
    n_checks++;
    if (pred_target !== et) begin
      n_fail++; $display("FAIL lookup_target pc=%h got=%h want=%h", pc, pred_target, et);
    end
  endtask

  // Drive one resolved branch; check stage-1 outputs just after the capturing edge
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    int unsigned i, t;
    bit          h;
    logic [1:0]  exp_cur;
    i = (pc / 4) % ENT;
    t = pc / (4 * ENT);
    h = model_hit(pc);
    exp_cur = h ? m_ctr[i] : 2'b00;
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    @(posedge clk); #1;
    n_checks++;
    if (fsm_cur !== exp_cur) begin
      n_fail++; $display("FAIL fsm_cur pc=%h got=%b want=%b", pc, fsm_cur, exp_cur);
    end
    n_checks++;
    if (fsm_taken !== tk) begin
      n_fail++; $display("FAIL fsm_taken pc=%h got=%b want=%b", pc, fsm_taken, tk);
    end
    last_cur = exp_cur;
    last_tk  = tk;
    if (h) begin
      m_ctr[i] = sat(m_ctr[i], tk);
      if (tk) m_tgt[i] = tgt;
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_ctr[i] = 2'b10;
    end
    upd_valid = 1'b0;
  endtask

  // Idle cycles; stage-1 outputs must hold their last value
  task automatic idle(input int n);
    upd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      n_checks++;
      if (fsm_cur !== last_cur || fsm_taken !== last_tk) begin
        n_fail++; $display("FAIL fsm_hold got=%b/%b want=%b/%b", fsm_cur, fsm_taken, last_cur, last_tk);
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (fsm_cur !== 2'b00 || fsm_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_fsm got=%b/%b want=00/0", fsm_cur, fsm_taken);
    end
    check_lookup(32'h100);
    for (int k = 0; k < 4; k++) check_lookup($urandom);
  endtask

  task automatic test_allocate();
    do_update(32'h100, 1'b1, 32'h200);
    idle(2);
    check_lookup(32'h100);
    n_checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_fail++; $display("FAIL alloc_0x100 got=%b/%b/%h want=1/1/00000200", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_not_taken_hit();
    do_update(32'h100, 1'b0, 32'h999);
    n_checks++;
    if (fsm_cur !== 2'b10) begin
      n_fail++; $display("FAIL nt_hit_cur got=%b want=10", fsm_cur);
    end
    idle(2);
    check_lookup(32'h100);
    n_checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL nt_hit_lookup got=%b/%b want=1/0", pred_hit, pred_taken);
    end
  endtask

  task automatic test_back_to_back();
    do_update(32'h100, 1'b1, 32'h200);   // ctr 01 -> 10
    idle(2);
    do_update(32'h100, 1'b1, 32'h204);   // sees 10
    do_update(32'h100, 1'b1, 32'h208);   // must see forwarded 11
    n_checks++;
    if (fsm_cur !== 2'b11) begin
      n_fail++; $display("FAIL b2b_forward got=%b want=11", fsm_cur);
    end
    idle(2);
    check_lookup(32'h100);
    do_update(32'h100, 1'b1, 32'h208);
    n_checks++;
    if (fsm_cur !== 2'b11) begin
      n_fail++; $display("FAIL b2b_final_ctr got=%b want=11", fsm_cur);
    end
    idle(2);
  endtask

  task automatic test_alias();
    do_update(32'h140, 1'b1, 32'h444);
    idle(2);
    check_lookup(32'h100);
    check_lookup(32'h140);
    n_checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h444) begin
      n_fail++; $display("FAIL alias_0x140 got=%b/%h want=1/00000444", pred_hit, pred_target);
    end
  endtask

  task automatic test_no_alloc_and_reset_s2();
    do_update(32'h300, 1'b0, 32'h600);
    idle(2);
    check_lookup(32'h300);
    n_checks++;
    if (pred_hit !== 1'b0) begin
      n_fail++; $display("FAIL no_alloc_0x300 got=%b want=0", pred_hit);
    end
    do_update(32'h500, 1'b1, 32'h700);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(2);
    check_lookup(32'h500);
    n_checks++;
    if (pred_hit !== 1'b0) begin
      n_fail++; $display("FAIL reset_s2_0x500 got=%b want=0", pred_hit);
    end
    check_lookup(32'h140);
  endtask

  // Random bursts over a small pc pool so indices and tags collide often
  task automatic test_random();
    logic [31:0] pc;
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < 8; k++) begin
        pc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        do_update(pc, 1'($urandom_range(0, 1)), $urandom);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);
      for (int t = 0; t < 3; t++)
        for (int i = 0; i < 4; i++)
          check_lookup((t << 6) | (i << 2));
    end
  endtask

  initial begin
    rst = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0;
    model_reset();
    test_reset();
    test_allocate();
    test_not_taken_hit();
    test_back_to_back();
    test_alias();
    test_no_alloc_and_reset_s2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
